// File: rtl/branch_resolver.sv
// branch_resolver: sits between fetch/execute and a 2-bit saturating-counter
// branch predictor. It requests predictions, queues them in order, and replays
// them against resolved outcomes to train the predictor and flag mispredicts.
// At most one handshake (fetch or resolve, resolve wins) is accepted per
// cycle. This keeps the registered request and result strobes mutually
// exclusive.
// Optional feature: define BR_RESOLVER_STATS_EN to build the saturating
// resolved-branch and mispredict counters. Without it, both read as zero.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             resolve_ready,
    output logic             request,
    input  logic             prediction,
    output logic             result,
    output logic             taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Prediction storage. It has no reset because the occupancy count
    // guards every read.
    logic             pred_mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] fifo_cnt_reg;   // captured predictions held
    logic [OCC_W-1:0] occ_reg;        // captured + requested-but-not-returned
    logic             request_reg;
    logic             capture_reg;    // prediction input is valid this cycle
    logic             result_reg;
    logic             taken_reg;
    logic             mispredict_reg;

    logic fifo_not_empty;
    logic resolve_valid_win;
    logic br_accept;
    logic resolve_accept;
    logic push;

    assign fifo_not_empty    = (fifo_cnt_reg != '0);
    assign resolve_valid_win = resolve_valid && fifo_not_empty;
    assign br_ready          = !rst && (occ_reg < OCC_W'(DEPTH)) && !resolve_valid_win;
    assign resolve_ready     = !rst && fifo_not_empty;
    assign br_accept         = br_valid && br_ready;
    assign resolve_accept    = resolve_valid && resolve_ready;

    // A return that lands while reset is asserted belongs to a discarded
    // request, so it is neither captured nor reported.
    assign push       = capture_reg && !rst;
    assign pred_valid = push;
    assign pred_taken = push && prediction;

    assign request    = request_reg;
    assign result     = result_reg;
    assign taken      = taken_reg;
    assign mispredict = mispredict_reg;

    // Capture each returned prediction at the FIFO tail.
    always_ff @(posedge clk) begin
        if (push) begin
            pred_mem_reg[wr_ptr_reg] <= prediction;
        end
    end

    // Handshake sequencing, queue pointers, occupancy and predictor strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_cnt_reg   <= '0;
            occ_reg        <= '0;
            request_reg    <= 1'b0;
            capture_reg    <= 1'b0;
            result_reg     <= 1'b0;
            taken_reg      <= 1'b0;
            mispredict_reg <= 1'b0;
        end else begin
            request_reg    <= br_accept;
            capture_reg    <= request_reg;
            result_reg     <= resolve_accept;
            taken_reg      <= resolve_accept && resolve_taken;
            mispredict_reg <= resolve_accept && (pred_mem_reg[rd_ptr_reg] != resolve_taken);

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (resolve_accept) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end

            case ({push, resolve_accept})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + OCC_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - OCC_W'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase

            // Accepts are exclusive, so at most one of these applies.
            if (br_accept) begin
                occ_reg <= occ_reg + OCC_W'(1);
            end else if (resolve_accept) begin
                occ_reg <= occ_reg - OCC_W'(1);
            end
        end
    end

`ifdef BR_RESOLVER_STATS_EN
    logic [CNT_W-1:0] br_count_reg;
    logic [CNT_W-1:0] mp_count_reg;

    // Saturating statistics driven by the registered training strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_reg <= '0;
            mp_count_reg <= '0;
        end else begin
            if (result_reg && (br_count_reg != '1)) begin
                br_count_reg <= br_count_reg + CNT_W'(1);
            end
            if (mispredict_reg && (mp_count_reg != '1)) begin
                mp_count_reg <= mp_count_reg + CNT_W'(1);
            end
        end
    end

    assign br_count = br_count_reg;
    assign mp_count = mp_count_reg;
`else
    assign br_count = '0;
    assign mp_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver. It contains a behavioural 2-bit
// saturating-counter predictor and a transaction-level reference model built
// from queues and integer counts. It honours BR_RESOLVER_STATS_EN the same
// way the design does.
module tb_branch_resolver;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BR_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             br_valid = 1'b0;
    logic             resolve_valid = 1'b0;
    logic             resolve_taken = 1'b0;
    logic             prediction = 1'b0;
    logic             br_ready;
    logic             pred_valid;
    logic             pred_taken;
    logic             resolve_ready;
    logic             request;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .resolve_ready (resolve_ready),
        .request       (request),
        .prediction    (prediction),
        .result        (result),
        .taken         (taken),
        .mispredict    (mispredict),
        .br_count      (br_count),
        .mp_count      (mp_count)
    );

    always #5 clk = ~clk;

    // Predictor: 2-bit saturating counter, power-up value 3, not reset by rst.
    logic [1:0] pred_ctr = 2'd3;
    always @(posedge clk) begin
        if (request) begin
            prediction <= pred_ctr[1];
        end else if (result) begin
            if (taken) pred_ctr <= (pred_ctr == 2'd3) ? 2'd3 : pred_ctr + 2'd1;
            else       pred_ctr <= (pred_ctr == 2'd0) ? 2'd0 : pred_ctr - 2'd1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (cyc=%0d)", tag, observed, expected, cyc);
        end
    endtask

    // Reference model state
    bit m_q[$];          // predictions sitting in the queue
    int m_occ = 0;       // queued + in-flight reservations
    bit m_req = 0;       // request expected this cycle
    bit m_pv  = 0;       // prediction return expected this cycle
    bit m_res = 0;
    bit m_tk  = 0;
    bit m_mp  = 0;
    int m_brc = 0;
    int m_mpc = 0;

    // What was observed in the most recent cycle
    bit last_brr, last_rsr, last_req, last_pv, last_pt, last_res, last_tk, last_mp;
    int obs_br_acc = 0;

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic run_cycle(input bit bv, input bit rv, input bit rt, input bit r);
        bit exp_brr, exp_rsr, exp_pv, br_acc, rs_acc, head;
        br_valid = bv; resolve_valid = rv; resolve_taken = rt; rst = r;
        @(negedge clk);
        exp_brr = !r && (m_occ < DEPTH) && !(rv && m_q.size() > 0);
        exp_rsr = !r && (m_q.size() > 0);
        exp_pv  = m_pv && !r;
        check_val("br_ready",      32'(br_ready),      32'(exp_brr));
        check_val("resolve_ready", 32'(resolve_ready), 32'(exp_rsr));
        check_val("request",       32'(request),       32'(m_req));
        check_val("pred_valid",    32'(pred_valid),    32'(exp_pv));
        check_val("pred_taken",    32'(pred_taken),    32'(exp_pv && prediction));
        check_val("result",        32'(result),        32'(m_res));
        check_val("taken",         32'(taken),         32'(m_tk));
        check_val("mispredict",    32'(mispredict),    32'(m_mp));
        check_val("br_count",      32'(br_count),      STATS ? 32'(m_brc) : 32'd0);
        check_val("mp_count",      32'(mp_count),      STATS ? 32'(m_mpc) : 32'd0);
        check_val("req_res_excl",  32'(request && result), 32'd0);
        last_brr = br_ready; last_rsr = resolve_ready; last_req = request;
        last_pv = pred_valid; last_pt = pred_taken; last_res = result;
        last_tk = taken; last_mp = mispredict;
        if (bv && br_ready) obs_br_acc++;
        br_acc = bv && exp_brr;
        rs_acc = rv && exp_rsr;
        if (r) begin
            m_q.delete();
            m_occ = 0; m_req = 0; m_pv = 0; m_res = 0; m_tk = 0; m_mp = 0;
            m_brc = 0; m_mpc = 0;
            $display("cyc=%0d reset", cyc);
        end else begin
            if (m_res && m_brc < CNT_MAX) m_brc++;
            if (m_mp && m_mpc < CNT_MAX) m_mpc++;
            if (rs_acc) begin
                head  = m_q.pop_front();
                m_res = 1; m_tk = rt; m_mp = (head != rt);
                m_occ--;
                $display("cyc=%0d resolve accepted outcome=%0d predicted=%0d", cyc, rt, head);
            end else begin
                m_res = 0; m_tk = 0; m_mp = 0;
            end
            if (m_pv) m_q.push_back(prediction);
            m_pv  = m_req;
            m_req = br_acc;
            if (br_acc) begin
                m_occ++;
                $display("cyc=%0d fetch accepted occ=%0d", cyc, m_occ);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Issue one branch into an empty queue, then resolve it with outcome rt.
    task automatic branch_then_resolve(input bit rt, output bit pt);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        pt = last_pt;
        run_cycle(1'b0, 1'b1, rt, 1'b0);
        idle(2);
    endtask

    initial begin
        bit pt;
        int acc0;

        // Reset for two cycles; the second is checked with everything at 0.
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_br_ready_after",      32'(last_brr), 32'd1);
        check_val("rst_resolve_ready_after", 32'(last_rsr), 32'd0);

        // Single branch with the predictor at 3, resolved not-taken.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("single_request", 32'(last_req), 32'd1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("single_pred_valid", 32'(last_pv), 32'd1);
        check_val("single_pred_taken", 32'(last_pt), 32'd1);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("single_result",     32'(last_res), 32'd1);
        check_val("single_taken",      32'(last_tk),  32'd0);
        check_val("single_mispredict", 32'(last_mp),  32'd1);
        idle(1);
        check_val("single_mp_count", 32'(mp_count), STATS ? 32'd1 : 32'd0);

        // Fill: five back-to-back offers, only DEPTH accepted.
        acc0 = obs_br_acc;
        for (int i = 0; i < 5; i++) run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("fill_accepts", 32'(obs_br_acc - acc0), 32'(DEPTH));
        check_val("fill_br_ready_full", 32'(last_brr), 32'd0);
        idle(2);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check_val("fill_br_ready_at_resolve", 32'(last_brr), 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("fill_br_ready_reopen", 32'(last_brr), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) run_cycle(1'b0, 1'b1, 1'(i), 1'b0);
        idle(2);

        // Contention: resolve wins, the branch goes through a cycle later.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_val("cont_br_ready",      32'(last_brr), 32'd0);
        check_val("cont_resolve_ready", 32'(last_rsr), 32'd1);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("cont_next_br_ready", 32'(last_brr), 32'd1);
        idle(2);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Training loop through the predictor's saturating counter.
        for (int i = 0; i < 4; i++) branch_then_resolve(1'b0, pt);
        branch_then_resolve(1'b1, pt);
        check_val("train_pred_after_nt", 32'(pt), 32'd0);
        branch_then_resolve(1'b1, pt);
        branch_then_resolve(1'b0, pt);
        check_val("train_pred_after_tt", 32'(pt), 32'd1);

        // Reset during a request cycle with two predictions queued.
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("midrst_request_cycle", 32'(last_req), 32'd1);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("midrst_resolve_ready", 32'(last_rsr), 32'd0);
        check_val("midrst_pred_valid",    32'(last_pv),  32'd0);
        check_val("midrst_br_count",      32'(br_count), 32'd0);
        check_val("midrst_mp_count",      32'(mp_count), 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_val("midrst_pred_valid_late", 32'(last_pv), 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            run_cycle(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < DEPTH + 4; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
